// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter over 8 requesters with one-hot and encoded grant; grant visible 1 cycle after request.
// No backpressure: the holder keeps the grant until done_i or a MAX_HOLD timeout, then one idle cycle re-arbitrates.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [7:0] grant_o,
  output logic [2:0] grant_idx_o,
  output logic       grant_valid_o,
  output logic       timeout_o
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [15:0]      req_dbl;
  logic [7:0]       req_rot;
  logic [2:0]       off;

  // Rotate requests so bit 0 is the pointer position; lowest set bit is the winner offset.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = req_dbl[ptr_q +: 8];
    off     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) off = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req_i) begin
          state_d = BUSY;
          idx_d   = ptr_q + off;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (done_i) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
        end else if ((MAX_HOLD > 0) && (cnt_q == HOLD_LAST)) begin
          state_d   = IDLE;
          ptr_d     = idx_q + 3'd1;
          timeout_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      ptr_q     <= 3'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_valid_o = (state_q == BUSY);
  assign grant_idx_o   = grant_valid_o ? idx_q : 3'd0;
  assign grant_o       = grant_valid_o ? (8'd1 << idx_q) : 8'd0;
  assign timeout_o     = timeout_q;

endmodule
